// File: rtl/isa_defs.sv
// Shared ISA definitions for the MIPS-subset core: field positions, opcode/funct
// encodings, ALU operation codes and immediate helpers.
package isa_defs;

    localparam int XLEN     = 32;
    localparam int NUM_REGS = 32;
    localparam int REG_AW   = 5;
    localparam logic [REG_AW-1:0] LINK_REG = 5'd31;

    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 26;
    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 21;
    localparam int RT_MSB  = 20;
    localparam int RT_LSB  = 16;
    localparam int RD_MSB  = 15;
    localparam int RD_LSB  = 11;
    localparam int SH_MSB  = 10;
    localparam int SH_LSB  = 6;
    localparam int FN_MSB  = 5;
    localparam int FN_LSB  = 0;
    localparam int IMM_MSB = 15;
    localparam int TGT_MSB = 25;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_SLT = 4'd4;
    localparam logic [3:0] ALU_SLL = 4'd5;
    localparam logic [3:0] ALU_SRL = 4'd6;
    localparam logic [3:0] ALU_LUI = 4'd7;

    typedef enum logic [1:0] {
        IMM_SIGN  = 2'd0,
        IMM_ZERO  = 2'd1,
        IMM_UPPER = 2'd2
    } imm_kind_e;

    function automatic logic [31:0] sign_ext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    function automatic logic [31:0] zero_ext16(input logic [15:0] v);
        return {16'h0000, v};
    endfunction

    function automatic logic [31:0] upper16(input logic [15:0] v);
        return {v, 16'h0000};
    endfunction

endpackage

// File: rtl/register_file.sv
// 32x32 register file: two asynchronous read ports, one write-back port and a
// link-write port that overrides write-back on LINK_REG. Entry 0 is never written.
module register_file
    import isa_defs::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        rs_addr_i,
    input  logic [4:0]        rt_addr_i,
    output logic [XLEN-1:0]   rs_val_o,
    output logic [XLEN-1:0]   rt_val_o,
    input  logic              wb_en_i,
    input  logic [4:0]        wb_addr_i,
    input  logic [XLEN-1:0]   wb_data_i,
    input  logic              link_en_i,
    input  logic [XLEN-1:0]   link_data_i
);

    logic [XLEN-1:0] regs_q [NUM_REGS];
    logic [XLEN-1:0] regs_d [NUM_REGS];

    // Next-state per entry; link write takes priority over write-back.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (i == 0) begin
                regs_d[i] = '0;
            end else if (link_en_i && (5'(i) == LINK_REG)) begin
                regs_d[i] = link_data_i;
            end else if (wb_en_i && (wb_addr_i == 5'(i))) begin
                regs_d[i] = wb_data_i;
            end else begin
                regs_d[i] = regs_q[i];
            end
        end
    end

    // Storage with asynchronous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign rs_val_o = regs_q[rs_addr_i];
    assign rt_val_o = regs_q[rt_addr_i];

endmodule

// File: rtl/instruction_decode.sv
// Decode stage: register file plus combinational R/I/J decode into datapath and
// fetch-feedback controls, with a sticky illegal-instruction flag.
module instruction_decode
    import isa_defs::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instruction,
    input  logic [31:0]       jump_dst_reg_val,
    input  logic              wb_en,
    input  logic [4:0]        wb_addr,
    input  logic [XLEN-1:0]   wb_data,
    output logic [XLEN-1:0]   rs_val,
    output logic [XLEN-1:0]   rt_val,
    output logic [31:0]       sxt_imm,
    output logic [31:0]       sxt_branch_addr,
    output logic [31:0]       jump_addr,
    output logic [4:0]        shamt,
    output logic [4:0]        dst_addr,
    output logic [3:0]        alu_ctrl,
    output logic              alu_src_imm,
    output logic              reg_write,
    output logic              mem_read,
    output logic              mem_write,
    output logic              mem_to_reg,
    output logic              cs_branch,
    output logic              cs_jump,
    output logic              illegal_instr
);

    logic [5:0]  opcode_s;
    logic [5:0]  funct_s;
    logic [4:0]  rs_s;
    logic [4:0]  rt_s;
    logic [4:0]  rd_s;
    logic [15:0] imm_s;
    imm_kind_e   imm_kind_s;
    logic        link_en_s;
    logic        jr_s;
    logic        illegal_s;
    logic        illegal_d;
    logic        illegal_q;

    assign opcode_s = instruction[OP_MSB:OP_LSB];
    assign funct_s  = instruction[FN_MSB:FN_LSB];
    assign rs_s     = instruction[RS_MSB:RS_LSB];
    assign rt_s     = instruction[RT_MSB:RT_LSB];
    assign rd_s     = instruction[RD_MSB:RD_LSB];
    assign imm_s    = instruction[IMM_MSB:0];
    assign shamt    = instruction[SH_MSB:SH_LSB];

    register_file u_register_file (
        .clk         (clk),
        .rst         (rst),
        .rs_addr_i   (rs_s),
        .rt_addr_i   (rt_s),
        .rs_val_o    (rs_val),
        .rt_val_o    (rt_val),
        .wb_en_i     (wb_en),
        .wb_addr_i   (wb_addr),
        .wb_data_i   (wb_data),
        .link_en_i   (link_en_s),
        .link_data_i (jump_dst_reg_val)
    );

    // Main decoder: anything unrecognised leaves every enable low.
    always_comb begin
        alu_ctrl    = ALU_ADD;
        alu_src_imm = 1'b0;
        reg_write   = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_to_reg  = 1'b0;
        cs_branch   = 1'b0;
        cs_jump     = 1'b0;
        link_en_s   = 1'b0;
        jr_s        = 1'b0;
        imm_kind_s  = IMM_SIGN;
        illegal_s   = 1'b0;
        case (opcode_s)
            OP_RTYPE: begin
                case (funct_s)
                    FN_ADD:  begin reg_write = 1'b1; alu_ctrl = ALU_ADD; end
                    FN_SUB:  begin reg_write = 1'b1; alu_ctrl = ALU_SUB; end
                    FN_AND:  begin reg_write = 1'b1; alu_ctrl = ALU_AND; end
                    FN_OR:   begin reg_write = 1'b1; alu_ctrl = ALU_OR;  end
                    FN_SLT:  begin reg_write = 1'b1; alu_ctrl = ALU_SLT; end
                    FN_SLL:  begin reg_write = 1'b1; alu_ctrl = ALU_SLL; end
                    FN_SRL:  begin reg_write = 1'b1; alu_ctrl = ALU_SRL; end
                    FN_JR:   begin cs_jump = 1'b1; jr_s = 1'b1; end
                    default: illegal_s = 1'b1;
                endcase
            end
            OP_ADDI: begin reg_write = 1'b1; alu_src_imm = 1'b1; alu_ctrl = ALU_ADD; end
            OP_ANDI: begin
                reg_write = 1'b1; alu_src_imm = 1'b1; alu_ctrl = ALU_AND; imm_kind_s = IMM_ZERO;
            end
            OP_ORI: begin
                reg_write = 1'b1; alu_src_imm = 1'b1; alu_ctrl = ALU_OR; imm_kind_s = IMM_ZERO;
            end
            OP_LUI: begin
                reg_write = 1'b1; alu_src_imm = 1'b1; alu_ctrl = ALU_LUI; imm_kind_s = IMM_UPPER;
            end
            OP_LW: begin
                reg_write = 1'b1; mem_read = 1'b1; mem_to_reg = 1'b1;
                alu_src_imm = 1'b1; alu_ctrl = ALU_ADD;
            end
            OP_SW:   begin mem_write = 1'b1; alu_src_imm = 1'b1; alu_ctrl = ALU_ADD; end
            OP_BEQ:  begin cs_branch = 1'b1; alu_ctrl = ALU_SUB; end
            OP_J:    cs_jump = 1'b1;
            OP_JAL:  begin cs_jump = 1'b1; link_en_s = 1'b1; end
            default: illegal_s = 1'b1;
        endcase
    end

    // Immediate formatting for the ALU operand-B path.
    always_comb begin
        case (imm_kind_s)
            IMM_ZERO:  sxt_imm = zero_ext16(imm_s);
            IMM_UPPER: sxt_imm = upper16(imm_s);
            IMM_SIGN:  sxt_imm = sign_ext16(imm_s);
            default:   sxt_imm = sign_ext16(imm_s);
        endcase
    end

    assign sxt_branch_addr = sign_ext16(imm_s);
    assign jump_addr = jr_s ? rs_val
                            : {jump_dst_reg_val[31:28], instruction[TGT_MSB:0], 2'b00};
    assign dst_addr  = (opcode_s == OP_RTYPE) ? rd_s : rt_s;

    assign illegal_d = illegal_q | illegal_s;

    // Sticky illegal flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign illegal_instr = illegal_q;

endmodule

// File: doc/instruction_decode.md
Name: instruction_decode

Overview:
- Decode stage of the single-cycle 32-bit MIPS-subset core. It sits directly downstream of instruction fetch and consumes `instruction` and `jump_dst_reg_val`.
- Holds the 32x32 register file, with two asynchronous read ports, one write-back port and one link-write path.
- Decodes R/I/J formats into datapath controls.
- Produces `cs_branch`, `cs_jump`, `jump_addr` and `sxt_branch_addr`, which feed back into fetch.

Parameters:
- XLEN, 32, datapath and register width.
- NUM_REGS, 32, register count; register 0 is hardwired to zero.
- LINK_REG, 31, destination index for the jal link write.

Ports:
- clk  input  1  core clock; all register writes occur on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- instruction  input  32  current instruction word from fetch.
- jump_dst_reg_val  input  32  PC+4 from fetch; the jal link value.
- wb_en  input  1  write-back enable from the writeback mux.
- wb_addr  input  5  write-back register index.
- wb_data  input  XLEN  write-back data.
- rs_val  output  XLEN  register[rs]; asynchronous read.
- rt_val  output  XLEN  register[rt]; asynchronous read.
- sxt_imm  output  32  immediate: sign-extended; zero-extended for andi/ori; imm<<16 for lui.
- sxt_branch_addr  output  32  sign-extended imm[15:0]; fetch shifts it.
- jump_addr  output  32  j/jal: {jump_dst_reg_val[31:28], instr[25:0], 2'b00}; jr: rs_val.
- shamt  output  5  instr[10:6].
- dst_addr  output  5  rd for R-type, rt for I-type.
- alu_ctrl  output  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 SLL, 6 SRL, 7 LUI-pass.
- alu_src_imm  output  1  selects sxt_imm as ALU operand B.
- reg_write, mem_read, mem_write, mem_to_reg  output  1 each  datapath controls.
- cs_branch  output  1  instruction is beq.
- cs_jump  output  1  instruction is j, jal or jr.
- illegal_instr  output  1  sticky flag: an unsupported opcode/funct has been decoded.

Behaviour:
- Reset is asynchronous and active-low (port `rst`).
  - While `rst`=0: all registers read 0 and `illegal_instr`=0.
  - Decoded control outputs remain a combinational function of `instruction`.
- Supported opcodes:
  - R-type, opcode 0: add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A, sll 0x00, srl 0x02, jr 0x08.
  - I-type: addi 0x08, andi 0x0C, ori 0x0D, lui 0x0F, lw 0x23, sw 0x2B, beq 0x04.
  - J-type: j 0x02, jal 0x03.
- Reads: combinational, zero latency. Index 0 always returns 0.
- Write timing: a register written at a clock edge is visible on read ports after that edge. A same-cycle read returns the old value; there is no bypass, because the core is single-cycle.
- Write-back: when `wb_en`=1 and `wb_addr`≠0, wb_data is written on posedge clk. A write to index 0 is silently dropped.
- jal:
  - Writes jump_dst_reg_val to LINK_REG on posedge clk, independent of `wb_en`.
  - If a wb write targets LINK_REG on the same edge, the link write wins.
  - reg_write=0 for jal so the external write-back stays idle.
- Control outputs per instruction:
  - jr: cs_jump=1, reg_write=0.
  - beq: cs_branch=1, alu_ctrl=SUB, reg_write=0.
  - sw: mem_write=1, reg_write=0.
  - lw: mem_read=1, mem_to_reg=1, alu_src_imm=1, alu_ctrl=ADD.
  - Any instruction not listed above (illegal): all enables=0, cs_branch=cs_jump=0.
- illegal_instr: sets on the first posedge clk with an illegal decode and holds until reset.
- Reset asserted mid-operation: register contents are cleared immediately; no partial write survives.
- All-zero instruction decodes as sll $0,$0,0, i.e. a legal NOP.

Decomposition:
- Shared package `isa_defs`:
  - opcode/funct localparams;
  - ALU_* codes;
  - LINK_REG;
  - field bit positions, for reuse by the ALU and control blocks.
- One natural sub-module: `register_file`, holding storage, reset, the two read ports, the write port and link-write priority.
- The decoder stays in instruction_decode.

Test Plan:
- Reset then read: hold rst=0, drive instruction 0x01095020 (add $10,$8,$9) → rs_val=rt_val=0 and reg_write=1, alu_ctrl=ADD, dst_addr=10.
- Write/read: wb_en=1, wb_addr=8, wb_data=0x12345678, one edge → rs_val for rs=8 reads 0x12345678. A write to index 0 with 0xFFFFFFFF → r0 still reads 0.
- jal link: instruction 0x0C000040, jump_dst_reg_val=0x00400008 → cs_jump=1, jump_addr=0x00000100; after the edge r31=0x00400008. Simultaneous wb to r31 with 0xDEAD → r31=0x00400008.
- beq/immediate: 0x1109FFFE → cs_branch=1, sxt_branch_addr=0xFFFFFFFE, alu_ctrl=SUB. Also check the three immediate forms:
  - ori 0x3508F000 → sxt_imm=0x0000F000;
  - addi with 0xF000 → sxt_imm=0xFFFFF000;
  - lui 0x3C081234 → sxt_imm=0x12340000.
- jr: r31=0x00400020, instruction 0x03E00008 → cs_jump=1, jump_addr=0x00400020, reg_write=0.
- Illegal: instruction 0xFC000000 → all enables 0 and illegal_instr=1 after the edge, staying 1 through subsequent legal instructions. Pulse rst low mid-cycle → illegal_instr=0 and all registers read 0 immediately.
